// File: rtl/nes_controller_reader_pkg.sv
// Purpose : shared types and constants for the NES pad poller.
// Latency : n/a (types and constants only).
// Backpr. : n/a. Contents: FSM state encoding, button bit positions, default timing.
package nes_controller_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CLK_LO = 3'd2,
    S_CLK_HI = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Bit positions inside the buttons vector (A shifts out of the pad first).
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int NUM_BTNS        = 8;
  localparam int HALF_PERIOD_DEF = 150;  // 6 us at 25.175 MHz
  localparam int CNT_W_DEF       = 10;

endpackage

// File: rtl/nes_controller_reader_if.sv
// Purpose : bundles the poll request, pad wires and button result of the NES poller.
// Latency : n/a (wiring only).
// Backpr. : none; trigger is a pulse, valid is a one-cycle strobe.
// Modports: master = poller side (drives pad strobes and results),
//           slave  = pad / consumer side (drives trigger and nes_data).
interface nes_controller_reader_if;
  import nes_controller_reader_pkg::*;

  logic                trigger;
  logic                nes_data;
  logic                nes_latch;
  logic                nes_clk;
  logic [NUM_BTNS-1:0] buttons;
  logic                valid;
  logic                busy;

  modport master (
    input  trigger, nes_data,
    output nes_latch, nes_clk, buttons, valid, busy
  );

  modport slave (
    output trigger, nes_data,
    input  nes_latch, nes_clk, buttons, valid, busy
  );

endinterface

// File: rtl/nes_controller_reader_phase_timer.sv
// Purpose : loadable down-counter timing one waveform phase; o_tc marks the phase's last cycle.
// Latency : loading L-1 gives a phase of exactly L cycles, o_tc high on the last one.
// Backpr. : none; a load always wins over counting.
// Ports   : i_clk, i_reset (sync, active-high), i_load, i_load_val, o_tc.
module nes_phase_timer #(
  parameter int W = 11
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/nes_controller_reader.sv
// Purpose : once per trigger, drives NES latch/clock and shifts in 8 active-low pad bits.
// Latency : trigger cycle to valid cycle = 17*HALF_PERIOD + 1 clk cycles.
// Backpr. : none; triggers while busy (including the DONE cycle) are dropped, never queued.
// Ports   : clk, reset (sync, active-high); bus (master modport): trigger, nes_data in;
//           nes_latch, nes_clk, buttons[7:0] {A,B,Sel,Start,Up,Down,Left,Right}, valid, busy out.
// Option  : define NES_INPUT_SYNC_EN to pass nes_data through a 2-flop synchronizer.
module nes_controller_reader
  import nes_controller_reader_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,  // 2..1023 (>= 3 with NES_INPUT_SYNC_EN)
  parameter int CNT_W       = CNT_W_DEF         // 2**CNT_W > HALF_PERIOD
) (
  input  logic                  clk,
  input  logic                  reset,
  nes_controller_reader_if.master bus
);

  // One extra bit so the timer also covers the 2*HALF_PERIOD latch pulse.
  localparam int TW = CNT_W + 1;
  localparam logic [TW-1:0] LD_LATCH = TW'(2 * HALF_PERIOD - 1);
  localparam logic [TW-1:0] LD_PHASE = TW'(HALF_PERIOD - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_idx;
  logic [NUM_BTNS-1:0] r_shift;
  logic [NUM_BTNS-1:0] w_shift_next;
  logic [NUM_BTNS-1:0] r_buttons;
  logic                r_valid;
  logic                r_latch;
  logic                r_nes_clk;
  logic                r_busy;

  logic                w_load;
  logic [TW-1:0]       w_load_val;
  logic                w_tc;
  logic                w_start;
  logic                w_sample;
  logic                w_idx_inc;
  logic                w_data;

`ifdef NES_INPUT_SYNC_EN
  // Resets to 1 (button released) so a poll right after reset reads nothing pressed.
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.nes_data};
    end
  end

  assign w_data = r_sync[1];
`else
  assign w_data = bus.nes_data;
`endif

  nes_phase_timer #(
    .W (TW)
  ) u_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // Current shift register with this cycle's (inverted) pad bit merged in.
  always_comb begin
    w_shift_next                 = r_shift;
    w_shift_next[3'd7 - r_idx]   = ~w_data;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = LD_PHASE;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_idx_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.trigger) begin
          w_start      = 1'b1;
          w_load       = 1'b1;
          w_load_val   = LD_LATCH;
          w_state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        if (w_tc) begin
          w_load       = 1'b1;
          w_state_next = S_CLK_LO;
        end
      end
      S_CLK_LO: begin
        if (w_tc) begin
          w_sample     = 1'b1;
          w_load       = 1'b1;
          w_state_next = (r_idx == 3'd7) ? S_DONE : S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (w_tc) begin
          w_idx_inc    = 1'b1;
          w_load       = 1'b1;
          w_state_next = S_CLK_LO;
        end
      end
      S_DONE: begin
        // Trigger is deliberately not looked at here: a new poll needs IDLE.
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_shift   <= '0;
      r_buttons <= '0;
      r_valid   <= 1'b0;
      r_latch   <= 1'b0;
      r_nes_clk <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_start) begin
        r_idx   <= 3'd0;
        r_shift <= '0;
      end else begin
        if (w_sample) begin
          r_shift <= w_shift_next;
        end
        if (w_idx_inc) begin
          r_idx <= r_idx + 3'd1;
        end
      end

      // buttons/valid are loaded on the edge that enters DONE so that the new
      // vector and its strobe are both visible during the DONE cycle itself.
      if (w_sample && (r_idx == 3'd7)) begin
        r_buttons <= w_shift_next;
      end

      // Pad strobes are decoded from the next state into flops: glitch-free
      // pad wires that stay aligned with r_state, and never high together.
      r_valid   <= (w_state_next == S_DONE);
      r_latch   <= (w_state_next == S_LATCH);
      r_nes_clk <= (w_state_next == S_CLK_HI);
      r_busy    <= (w_state_next != S_IDLE);
    end
  end

  assign bus.nes_latch = r_latch;
  assign bus.nes_clk   = r_nes_clk;
  assign bus.buttons   = r_buttons;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_nes_controller_reader.sv
module tb_nes_controller_reader;
  import nes_controller_reader_pkg::*;

`ifdef NES_INPUT_SYNC_EN
  localparam int H = 3;
`else
  localparam int H = 2;
`endif
  localparam int POLL = 17 * H + 1;   // trigger cycle -> valid cycle
  localparam int RUN  = POLL + 2 * H + 6;

  logic clk = 1'b0;
  logic reset = 1'b1;

  nes_controller_reader_if bus ();

  nes_controller_reader #(
    .HALF_PERIOD (H),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural pad: latch reloads, each rising nes_clk advances one button;
  // data is active-low and reads released (1) after the eighth bit.
  logic [7:0] pad_pressed = 8'h00;
  int         pad_bit = 0;
  logic       pad_prev_clk = 1'b0;

  always @(negedge clk) begin
    if (bus.nes_latch === 1'b1) pad_bit = 0;
    else if (bus.nes_clk === 1'b1 && pad_prev_clk === 1'b0) pad_bit = pad_bit + 1;
    pad_prev_clk = bus.nes_clk;
    bus.nes_data = (pad_bit < 8) ? ~pad_pressed[7 - pad_bit] : 1'b1;
  end

  logic [7:0] exp_btn = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pad waveform for cycle k after the trigger cycle, from the timing rules.
  function automatic logic exp_latch(input int k);
    return (k >= 1 && k <= 2 * H);
  endfunction

  function automatic logic exp_clk(input int k);
    int off;
    if (k < 2 * H + 1 || k > 17 * H) return 1'b0;
    off = k - (2 * H + 1);
    return ((off / H) % 2) == 1;
  endfunction

  // One full poll: trigger, observe RUN cycles, compare against the model.
  task automatic poll(input string tag, input logic [7:0] pressed, input int retrig_k);
    int wave_bad = 0, overlap = 0, busy_bad = 0, btn_bad = 0, valid_cnt = 0, valid_k = -1;
    logic [7:0] btn_at_valid = 8'hxx;
    pad_pressed = pressed;
    @(negedge clk);
    bus.trigger = 1'b1;
    for (int k = 1; k <= RUN; k++) begin
      @(negedge clk);
      bus.trigger = (k == retrig_k);
      if (bus.nes_latch !== exp_latch(k) || bus.nes_clk !== exp_clk(k)) wave_bad++;
      if (bus.nes_latch === 1'b1 && bus.nes_clk === 1'b1) overlap++;
      if (bus.busy !== (k <= POLL)) busy_bad++;
      if (bus.valid === 1'b1) begin
        valid_cnt++;
        valid_k = k;
        btn_at_valid = bus.buttons;
      end else if (valid_cnt == 0 && bus.buttons !== exp_btn) btn_bad++;
      else if (valid_cnt > 0 && bus.buttons !== pressed) btn_bad++;
    end
    bus.trigger = 1'b0;
    exp_btn = pressed;
    chk({tag, "_wave"}, wave_bad, 0);
    chk({tag, "_overlap"}, overlap, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_valid_cnt"}, valid_cnt, 1);
    chk({tag, "_valid_cyc"}, valid_k, POLL);
    chk({tag, "_buttons"}, {24'd0, btn_at_valid}, {24'd0, pressed});
    chk({tag, "_btn_hold"}, btn_bad, 0);
  endtask

  initial begin
    logic [7:0] pat;
    int bad;
    bus.trigger = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_buttons", {24'd0, bus.buttons}, 32'h0);
    chk("rst_valid", {31'd0, bus.valid}, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'h0);
    chk("rst_latch", {31'd0, bus.nes_latch}, 32'h0);
    chk("rst_clk", {31'd0, bus.nes_clk}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    poll("none", 8'h00, -1);
    poll("a_right", 8'((1 << BTN_A) | (1 << BTN_RIGHT)), -1);
    chk("a_right_val", {24'd0, exp_btn}, 32'h81);
    poll("up_left", 8'((1 << BTN_UP) | (1 << BTN_LEFT)), -1);
    poll("release", 8'h00, -1);
    poll("retrig10", 8'($urandom), 10);
    poll("retrig_done", 8'($urandom), POLL);
`ifdef NES_INPUT_SYNC_EN
    poll("sync_5a", 8'h5A, -1);
`endif
    for (int i = 0; i < 6; i++) begin
      pat = 8'($urandom);
      poll("rand", pat, -1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // Reset during CLK_HI of bit 4 after an all-pressed poll.
    poll("all", 8'hFF, -1);
    pad_pressed = 8'($urandom);
    @(negedge clk);
    bus.trigger = 1'b1;
    for (int k = 1; k <= 11 * H + 1; k++) begin
      @(negedge clk);
      bus.trigger = 1'b0;
    end
    chk("bit4_hi_clk", {31'd0, bus.nes_clk}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_btn = 8'h00;
    chk("midrst_buttons", {24'd0, bus.buttons}, 32'h0);
    chk("midrst_clk", {31'd0, bus.nes_clk}, 32'h0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'h0);
    chk("midrst_valid", {31'd0, bus.valid}, 32'h0);
    bad = 0;
    for (int k = 0; k < POLL + 10; k++) begin
      @(negedge clk);
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.buttons !== 8'h00) bad++;
    end
    chk("midrst_quiet", bad, 0);
    poll("after_rst", 8'($urandom), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
